toaplan2_sync_ctrl: RTL and testbench
=====================================

// Module: toaplan2_sync_ctrl
// PURPOSE
//  Lock supervisor for the Toaplan2 capture frontend. Measures CSYNC line periods and the lines
//  per frame delimited by the frontend's frame_change. Runs a lock state machine on the result.
//  Gates downstream video (mute) and reports the measured timing to the scaler/OSD side.
//  Sits beside toaplan2_frontend in the VCLK domain.
// PARAMETERS
//  NOM_LINE_VCLKS   864   nominal line period in VCLK (432 px x 2)
//  LINE_TOL         8     +/- VCLK tolerance for a good line
//  MIN_LINE_VCLKS   432   intervals shorter than this are equalization/serration; ignored
//  NOM_LINES        263   nominal counted lines per frame
//  LINES_TOL        2     +/- line tolerance for a good frame
//  MAX_BAD_LINES    8     max out-of-tolerance counted lines allowed in a good frame
//  LOCK_FRAMES      4     consecutive good frames needed to lock
//  UNLOCK_FRAMES    8     consecutive bad frames in HOLD before falling back to ACQUIRE
//  TIMEOUT_VCLKS    4095  VCLKs without a CSYNC falling edge before going to IDLE
// PORTS
//  VCLK_i              in   1   video clock
//  reset_n             in   1   asynchronous active-low reset
//  CSYNC_i             in   1   raw composite sync, active low
//  frame_change_i      in   1   frontend frame_change level; its rising edge ends a frame
//  vclks_per_frame_i   in   22  frontend frame length; captured for reporting only
//  lock_o              out  1   1 in LOCKED or HOLD
//  mute_o              out  1   1 unless state is LOCKED
//  state_o             out  2   0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 HOLD
//  line_vclks_o        out  12  last counted line period in VCLK (saturates at 4095)
//  lines_per_frame_o   out  10  counted lines in the last completed frame
//  frame_vclks_o       out  22  vclks_per_frame_i latched at the last frame end
//  frame_good_o        out  1   one-cycle pulse when a completed frame is judged good
// BEHAVIOUR
//  Reset values
//   - State IDLE; mute_o=1; lock_o=0; frame_good_o=0.
//   - All counters, line_vclks_o, lines_per_frame_o and frame_vclks_o are 0.
//   - Reset is async assert and sync deassert usage; reset mid-frame discards all partial counts.
//  Input path
//   - CSYNC_i goes through a 2-FF synchronizer.
//   - A falling edge is registered 1 cycle after the second FF, so 3 VCLK of latency from the pin.
//   - frame_change_i rising edge is detected with a single register; it is already in the VCLK domain.
//  Line measurement
//   - gap_ctr (12b, saturating) counts VCLK since the last falling edge.
//   - On an edge with gap_ctr >= MIN_LINE_VCLKS the line is counted.
//     line_ctr increments; line_vclks_o <= gap_ctr.
//     If |gap_ctr-NOM_LINE_VCLKS| > LINE_TOL, bad_ctr increments.
//   - Shorter intervals are ignored, except that gap_ctr still restarts at 1.
//   - line_ctr saturates at 1023; bad_ctr saturates at 255.
//  Frame end (frame_change rise)
//   - good = |line_ctr-NOM_LINES| <= LINES_TOL && bad_ctr <= MAX_BAD_LINES.
//   - Latch lines_per_frame_o and frame_vclks_o, pulse frame_good_o if good, then clear line_ctr and bad_ctr.
//   - If a counted edge lands in the same cycle, it belongs to the closing frame: it is included
//     in the evaluation and the counters clear to 0.
//  Frame ends occurring in IDLE are evaluated for reporting only; they do not move the state machine.
//  State machine, one update per frame end unless noted
//   - IDLE    -> ACQUIRE on any CSYNC falling edge; good_run=0.
//   - ACQUIRE: good frame increments good_run, bad frame clears it.
//              good_run==LOCK_FRAMES-1 plus a good frame -> LOCKED.
//   - LOCKED  -> HOLD on a bad frame; bad_run=1.
//   - HOLD:    good frame -> LOCKED with bad_run=0.
//              bad frame increments bad_run; reaching UNLOCK_FRAMES -> ACQUIRE with good_run=0.
//   - Any state -> IDLE when gap_ctr reaches TIMEOUT_VCLKS (evaluated every cycle, highest priority).
//     Line and frame counters clear.
//  Outputs are registered and derived from the next state, so mute_o/lock_o change in the
//  cycle after the deciding frame_change edge.
// STRUCTURE
//  - Shared package toaplan2_pkg: state enum (IDLE/ACQUIRE/LOCKED/HOLD as 2'd0..3) and the
//    TP2 nominal timing constants (432/263), shared with the frontend.
//  - One sub-module, toaplan2_sync_meas: synchronizer, edge detect, gap/line/bad counters and
//    the frame-good verdict. The top-level module holds the FSM and output registers.
// TESTING
//  1 Nominal CSYNC (864-VCLK lines, 263 lines, frame_change every frame)
//    -> ACQUIRE after the first edge; LOCKED, mute_o=0 one cycle after the 4th good frame end;
//    lines_per_frame_o=263, line_vclks_o=864.
//  2 While LOCKED, one frame with 270 lines -> HOLD, lock_o=1, mute_o=1;
//    next nominal frame -> LOCKED.
//  3 While LOCKED, 8 consecutive 250-line frames -> HOLD after the 1st, ACQUIRE after the 8th;
//    then 4 good frames -> LOCKED.
//  4 CSYNC held high for 4095 VCLK in any state -> IDLE, mute_o=1, lock_o=0;
//    a 4094-VCLK gap keeps the state.
//  5 Boundaries: line of 872 VCLK is good and 873 is bad; 9 bad lines in a frame -> bad frame,
//    8 -> good; 300-VCLK serration pulses do not change line_ctr.
//  6 Counted edge coincident with the frame_change rise -> included in lines_per_frame_o;
//    reset_n low mid-frame -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/toaplan2_pkg.sv
// Shared Toaplan2 video definitions: lock-state encoding, nominal raster timing and
// counter widths used by the capture frontend and its sync supervisor.
package toaplan2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLD    = 2'd3
  } tp2_state_e;

  localparam int TP2_H_PIXELS        = 432;
  localparam int TP2_LINES           = 263;
  localparam int TP2_VCLKS_PER_PIXEL = 2;

  localparam int GAP_W   = 12;
  localparam int LINE_W  = 10;
  localparam int BAD_W   = 8;
  localparam int FRAME_W = 22;
  localparam int RUN_W   = 4;

  function automatic logic [12:0] abs_diff(input logic [12:0] a, input logic [12:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/toaplan2_sync_meas.sv
// CSYNC synchronizer and falling-edge detector, line/frame measurement counters and the
// per-frame good/bad verdict presented combinationally in the frame_change rise cycle.
module toaplan2_sync_meas
  import toaplan2_pkg::*;
#(
  parameter int NOM_LINE_VCLKS = TP2_H_PIXELS * TP2_VCLKS_PER_PIXEL,
  parameter int LINE_TOL       = 8,
  parameter int MIN_LINE_VCLKS = TP2_H_PIXELS,
  parameter int NOM_LINES      = TP2_LINES,
  parameter int LINES_TOL      = 2,
  parameter int MAX_BAD_LINES  = 8,
  parameter int TIMEOUT_VCLKS  = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csync_i,
  input  logic               frame_change_i,
  input  logic [FRAME_W-1:0] vclks_per_frame_i,
  output logic               fall_o,
  output logic               frame_end_o,
  output logic               frame_good_now_o,
  output logic               timeout_o,
  output logic [GAP_W-1:0]   line_vclks_o,
  output logic [LINE_W-1:0]  lines_per_frame_o,
  output logic [FRAME_W-1:0] frame_vclks_o,
  output logic               frame_good_o
);

  localparam logic [GAP_W-1:0] MIN_LINE = GAP_W'(MIN_LINE_VCLKS);
  localparam logic [GAP_W-1:0] TIMEOUT  = GAP_W'(TIMEOUT_VCLKS);
  localparam logic [12:0]      NOM_LINE = 13'(NOM_LINE_VCLKS);
  localparam logic [12:0]      LTOL     = 13'(LINE_TOL);
  localparam logic [12:0]      NOM_LN   = 13'(NOM_LINES);
  localparam logic [12:0]      LNTOL    = 13'(LINES_TOL);
  localparam logic [BAD_W-1:0] MAX_BAD  = BAD_W'(MAX_BAD_LINES);

  logic               csync_s1_q, csync_s2_q, csync_s3_q;
  logic               fall_q, fall_d;
  logic               fc_prev_q;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [LINE_W-1:0]  line_ctr_q, line_ctr_d;
  logic [BAD_W-1:0]   bad_ctr_q, bad_ctr_d;
  logic [GAP_W-1:0]   line_vclks_q, line_vclks_d;
  logic [LINE_W-1:0]  lines_pf_q, lines_pf_d;
  logic [FRAME_W-1:0] frame_vclks_q, frame_vclks_d;
  logic               frame_good_q, frame_good_d;

  logic               fc_rise;
  logic               timeout;
  logic               counted;
  logic               line_bad;
  logic [LINE_W-1:0]  line_inc;
  logic [BAD_W-1:0]   bad_inc;
  logic               good_now;

  always_comb begin
    fall_d   = csync_s3_q & ~csync_s2_q;
    fc_rise  = frame_change_i & ~fc_prev_q;
    timeout  = (gap_q == TIMEOUT);
    counted  = fall_q && (gap_q >= MIN_LINE);
    line_bad = abs_diff({1'b0, gap_q}, NOM_LINE) > LTOL;

    // The line closed by an edge in the frame-end cycle still belongs to the closing frame.
    line_inc = (counted && (line_ctr_q != '1)) ? line_ctr_q + LINE_W'(1) : line_ctr_q;
    bad_inc  = (counted && line_bad && (bad_ctr_q != '1)) ? bad_ctr_q + BAD_W'(1) : bad_ctr_q;
    good_now = (abs_diff({3'b000, line_inc}, NOM_LN) <= LNTOL) && (bad_inc <= MAX_BAD);

    if (fall_q) begin
      gap_d = GAP_W'(1);
    end else if (gap_q != '1) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end

    line_ctr_d    = (fc_rise || timeout) ? '0 : line_inc;
    bad_ctr_d     = (fc_rise || timeout) ? '0 : bad_inc;
    line_vclks_d  = counted ? gap_q : line_vclks_q;
    lines_pf_d    = fc_rise ? line_inc : lines_pf_q;
    frame_vclks_d = fc_rise ? vclks_per_frame_i : frame_vclks_q;
    frame_good_d  = fc_rise && good_now;
  end

  // Synchronizer resets to the idle (high) level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csync_s1_q    <= 1'b1;
      csync_s2_q    <= 1'b1;
      csync_s3_q    <= 1'b1;
      fall_q        <= 1'b0;
      fc_prev_q     <= 1'b0;
      gap_q         <= '0;
      line_ctr_q    <= '0;
      bad_ctr_q     <= '0;
      line_vclks_q  <= '0;
      lines_pf_q    <= '0;
      frame_vclks_q <= '0;
      frame_good_q  <= 1'b0;
    end else begin
      csync_s1_q    <= csync_i;
      csync_s2_q    <= csync_s1_q;
      csync_s3_q    <= csync_s2_q;
      fall_q        <= fall_d;
      fc_prev_q     <= frame_change_i;
      gap_q         <= gap_d;
      line_ctr_q    <= line_ctr_d;
      bad_ctr_q     <= bad_ctr_d;
      line_vclks_q  <= line_vclks_d;
      lines_pf_q    <= lines_pf_d;
      frame_vclks_q <= frame_vclks_d;
      frame_good_q  <= frame_good_d;
    end
  end

  assign fall_o            = fall_q;
  assign frame_end_o       = fc_rise;
  assign frame_good_now_o  = good_now;
  assign timeout_o         = timeout;
  assign line_vclks_o      = line_vclks_q;
  assign lines_per_frame_o = lines_pf_q;
  assign frame_vclks_o     = frame_vclks_q;
  assign frame_good_o      = frame_good_q;

endmodule

// File: rtl/toaplan2_sync_ctrl.sv
// Toaplan2 sync lock supervisor: runs the IDLE/ACQUIRE/LOCKED/HOLD lock machine on the
// per-frame verdicts from the measurement block and drives the registered mute/lock outputs.
module toaplan2_sync_ctrl
  import toaplan2_pkg::*;
#(
  parameter int NOM_LINE_VCLKS = TP2_H_PIXELS * TP2_VCLKS_PER_PIXEL,
  parameter int LINE_TOL       = 8,
  parameter int MIN_LINE_VCLKS = TP2_H_PIXELS,
  parameter int NOM_LINES      = TP2_LINES,
  parameter int LINES_TOL      = 2,
  parameter int MAX_BAD_LINES  = 8,
  parameter int LOCK_FRAMES    = 4,
  parameter int UNLOCK_FRAMES  = 8,
  parameter int TIMEOUT_VCLKS  = 4095
) (
  input  logic               VCLK_i,
  input  logic               reset_n,
  input  logic               CSYNC_i,
  input  logic               frame_change_i,
  input  logic [FRAME_W-1:0] vclks_per_frame_i,
  output logic               lock_o,
  output logic               mute_o,
  output logic [1:0]         state_o,
  output logic [GAP_W-1:0]   line_vclks_o,
  output logic [LINE_W-1:0]  lines_per_frame_o,
  output logic [FRAME_W-1:0] frame_vclks_o,
  output logic               frame_good_o
);

  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_FRAMES - 1);
  localparam logic [RUN_W-1:0] UNLOCK_N  = RUN_W'(UNLOCK_FRAMES);

  logic fall;
  logic frame_end;
  logic frame_good_now;
  logic timeout;

  toaplan2_sync_meas #(
    .NOM_LINE_VCLKS (NOM_LINE_VCLKS),
    .LINE_TOL       (LINE_TOL),
    .MIN_LINE_VCLKS (MIN_LINE_VCLKS),
    .NOM_LINES      (NOM_LINES),
    .LINES_TOL      (LINES_TOL),
    .MAX_BAD_LINES  (MAX_BAD_LINES),
    .TIMEOUT_VCLKS  (TIMEOUT_VCLKS)
  ) u_meas (
    .clk               (VCLK_i),
    .rst_n             (reset_n),
    .csync_i           (CSYNC_i),
    .frame_change_i    (frame_change_i),
    .vclks_per_frame_i (vclks_per_frame_i),
    .fall_o            (fall),
    .frame_end_o       (frame_end),
    .frame_good_now_o  (frame_good_now),
    .timeout_o         (timeout),
    .line_vclks_o      (line_vclks_o),
    .lines_per_frame_o (lines_per_frame_o),
    .frame_vclks_o     (frame_vclks_o),
    .frame_good_o      (frame_good_o)
  );

  tp2_state_e       state_q, state_d;
  logic [RUN_W-1:0] good_run_q, good_run_d;
  logic [RUN_W-1:0] bad_run_q, bad_run_d;
  logic             lock_q, lock_d;
  logic             mute_q, mute_d;

  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;

    // Loss of CSYNC overrides any frame verdict arriving in the same cycle.
    if (timeout) begin
      state_d    = ST_IDLE;
      good_run_d = '0;
      bad_run_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_d    = ST_ACQUIRE;
            good_run_d = '0;
          end
        end
        ST_ACQUIRE: begin
          if (frame_end) begin
            if (!frame_good_now) begin
              good_run_d = '0;
            end else if (good_run_q == LOCK_LAST) begin
              state_d    = ST_LOCKED;
              good_run_d = '0;
            end else begin
              good_run_d = good_run_q + RUN_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (frame_end && !frame_good_now) begin
            state_d   = ST_HOLD;
            bad_run_d = RUN_W'(1);
          end
        end
        ST_HOLD: begin
          if (frame_end) begin
            if (frame_good_now) begin
              state_d   = ST_LOCKED;
              bad_run_d = '0;
            end else if ((bad_run_q + RUN_W'(1)) == UNLOCK_N) begin
              state_d    = ST_ACQUIRE;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              bad_run_d = bad_run_q + RUN_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    lock_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
    mute_d = (state_d != ST_LOCKED);
  end

  always_ff @(posedge VCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      good_run_q <= '0;
      bad_run_q  <= '0;
      lock_q     <= 1'b0;
      mute_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      lock_q     <= lock_d;
      mute_q     <= mute_d;
    end
  end

  assign lock_o  = lock_q;
  assign mute_o  = mute_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_toaplan2_sync_ctrl.sv
// Scoreboard bench for toaplan2_sync_ctrl with scaled raster timing (96-VCLK lines,
// 12-line frames) so each frame is about a thousand VCLK; the timeout stays at 4095.
module tb_toaplan2_sync_ctrl;

  localparam int NOM_P = 96;
  localparam int ST_I = 0, ST_A = 1, ST_L = 2, ST_H = 3;

  typedef struct packed {
    logic [1:0]  st;
    logic        lock;
    logic        mute;
    logic        full;
    logic        good;
    logic [9:0]  lines;
    logic [11:0] lv;
    logic [21:0] fv;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        csync;
  logic        frame_change;
  logic [21:0] vclks_per_frame;
  logic        lock_o, mute_o, frame_good_o;
  logic [1:0]  state_o;
  logic [11:0] line_vclks_o;
  logic [9:0]  lines_per_frame_o;
  logic [21:0] frame_vclks_o;

  always #5 clk = ~clk;

  toaplan2_sync_ctrl #(
    .NOM_LINE_VCLKS (NOM_P),
    .LINE_TOL       (8),
    .MIN_LINE_VCLKS (48),
    .NOM_LINES      (12),
    .LINES_TOL      (2),
    .MAX_BAD_LINES  (8),
    .LOCK_FRAMES    (4),
    .UNLOCK_FRAMES  (8),
    .TIMEOUT_VCLKS  (4095)
  ) dut (
    .VCLK_i            (clk),
    .reset_n           (reset_n),
    .CSYNC_i           (csync),
    .frame_change_i    (frame_change),
    .vclks_per_frame_i (vclks_per_frame),
    .lock_o            (lock_o),
    .mute_o            (mute_o),
    .state_o           (state_o),
    .line_vclks_o      (line_vclks_o),
    .lines_per_frame_o (lines_per_frame_o),
    .frame_vclks_o     (frame_vclks_o),
    .frame_good_o      (frame_good_o)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;
  int    probe_req = 0;
  int    probe_done = 0;
  int    frame_id = 0;

  function automatic exp_t mk(input int st, input bit full, input int lines, input bit good,
                              input int lv, input int fv);
    exp_t e;
    e.st    = 2'(st);
    e.lock  = (st == ST_L) || (st == ST_H);
    e.mute  = (st != ST_L);
    e.full  = full;
    e.good  = good;
    e.lines = 10'(lines);
    e.lv    = 12'(lv);
    e.fv    = 22'(fv);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic do_check();
    exp_t  e;
    string nm;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty actual=0 required=1 at t=%0t", $time);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, ".state"}, int'(state_o), int'(e.st));
      chk({nm, ".lock"}, int'(lock_o), int'(e.lock));
      chk({nm, ".mute"}, int'(mute_o), int'(e.mute));
      chk({nm, ".good"}, int'(frame_good_o), int'(e.good));
      if (e.full) begin
        chk({nm, ".lines"}, int'(lines_per_frame_o), int'(e.lines));
        chk({nm, ".line_vclks"}, int'(line_vclks_o), int'(e.lv));
        chk({nm, ".frame_vclks"}, int'(frame_vclks_o), int'(e.fv));
      end
      $display("check %s state=%0d lock=%0b mute=%0b good=%0b lines=%0d line_vclks=%0d",
               nm, state_o, lock_o, mute_o, frame_good_o, lines_per_frame_o, line_vclks_o);
    end
  endtask

  // Monitor: a frame report is due the cycle after each frame_change rise; probes on request.
  initial begin
    logic fc_last;
    fc_last = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (frame_change && !fc_last) begin
        do_check();
      end else if (probe_req != probe_done) begin
        probe_done++;
        do_check();
      end
      fc_last = frame_change;
    end
  end

  task automatic line(input int p, input int fc_off, input int probe_off, input string nm,
                      input exp_t e);
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      csync = (c < 16) ? 1'b0 : 1'b1;
      if (c == fc_off) begin
        exp_q.push_back(e);
        name_q.push_back(nm);
        frame_change = 1'b1;
      end
      if (fc_off >= 0 && c == fc_off + 4) frame_change = 1'b0;
      if (c == probe_off) begin
        exp_q.push_back(e);
        name_q.push_back(nm);
        probe_req++;
      end
    end
  endtask

  task automatic probe_line(input string nm, input int p, input int st);
    line(p, -1, 10, nm, mk(st, 1'b0, 0, 1'b0, 0, 0));
  endtask

  task automatic frame(input string nm, input int n, input int n_alt, input int p_alt,
                       input int fc_off, input int st, input int lines, input bit good,
                       input int lv);
    exp_t e;
    int   fv;
    frame_id++;
    fv = 1000 + frame_id * 13;
    vclks_per_frame = 22'(fv);
    e = mk(st, 1'b1, lines, good, lv, fv);
    for (int i = 0; i < n; i++) begin
      line((i < n_alt) ? p_alt : NOM_P, (i == n - 1) ? fc_off : -1, -1, nm, e);
    end
  endtask

  task automatic reset_probe(input string nm);
    exp_q.push_back(mk(ST_I, 1'b1, 0, 1'b0, 0, 0));
    name_q.push_back(nm);
    probe_req++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n         = 1'b0;
    csync           = 1'b1;
    frame_change    = 1'b0;
    vclks_per_frame = '0;
    repeat (3) @(negedge clk);
    reset_probe("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Acquisition from nominal sync
    probe_line("prime", NOM_P, ST_A);
    for (int k = 1; k <= 4; k++)
      frame($sformatf("nom%0d", k), 12, 0, NOM_P, 40, (k == 4) ? ST_L : ST_A, 12, 1'b1, NOM_P);

    // One long frame then recovery
    frame("long19", 19, 0, NOM_P, 40, ST_H, 19, 1'b0, NOM_P);
    frame("recover", 12, 0, NOM_P, 40, ST_L, 12, 1'b1, NOM_P);

    // Eight short frames drop to ACQUIRE, then relock
    for (int k = 1; k <= 8; k++)
      frame($sformatf("short%0d", k), 6, 0, NOM_P, 40, (k == 8) ? ST_A : ST_H, 6, 1'b0, NOM_P);
    for (int k = 1; k <= 4; k++)
      frame($sformatf("reacq%0d", k), 12, 0, NOM_P, 40, (k == 4) ? ST_L : ST_A, 12, 1'b1, NOM_P);

    // Line tolerance, bad-line count limit and serration rejection
    frame("tol104x9", 12, 9, 104, 40, ST_L, 12, 1'b1, NOM_P);
    frame("tol105x9", 12, 9, 105, 40, ST_H, 12, 1'b0, NOM_P);
    frame("tol105x8", 12, 8, 105, 40, ST_L, 12, 1'b1, NOM_P);
    frame("serration", 16, 4, 30, 40, ST_L, 12, 1'b1, NOM_P);

    // CSYNC timeout boundary
    line(4094, -1, -1, "gap4094", mk(ST_L, 1'b0, 0, 1'b0, 0, 0));
    probe_line("gap4094", NOM_P, ST_L);
    line(4095, -1, -1, "gap4095", mk(ST_I, 1'b0, 0, 1'b0, 0, 0));
    probe_line("gap4095", NOM_P, ST_I);

    // Coincident counted edge and frame end
    frame("after_to", 12, 0, NOM_P, 40, ST_A, 12, 1'b1, NOM_P);
    frame("coincident", 12, 0, NOM_P, 3, ST_A, 12, 1'b1, NOM_P);
    frame("post_coinc", 12, 0, NOM_P, 40, ST_A, 12, 1'b1, NOM_P);

    // Reset mid-frame
    for (int k = 0; k < 5; k++) line(NOM_P, -1, -1, "midframe", mk(ST_A, 1'b0, 0, 1'b0, 0, 0));
    @(negedge clk);
    reset_n = 1'b0;
    reset_probe("mid_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    probe_line("prime2", NOM_P, ST_A);
    frame("post_reset", 12, 0, NOM_P, 40, ST_A, 12, 1'b1, NOM_P);

    repeat (10) @(negedge clk);
    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
